des_key_schedule: RTL and testbench

Sequential DES subkey generator for the round datapath. It produces the 48-bit round keys K1..K16, in encrypt or decrypt order, one per handshake. Each key is XORed with the E-expanded right half, and the 6-bit slices of that result feed the S_block1..S_block8 substitution stage.

---
 rtl/des_pkg.sv | 61 ++++++
 rtl/des_pc2.sv | 14 +
 rtl/des_key_schedule.sv | 131 +++++++++++++
 tb/tb_des_key_schedule.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, per-round shift table, FSM states
// and the permutation/rotation helpers shared by the schedule datapath.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned PC1_W    = 2 * CD_W;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [6:0] PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [5:0] PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Rotation amount for schedule round rnd (1..16).
    function automatic logic [1:0] shift_of(input logic [4:0] rnd);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 1; i <= 16; i++) begin
            if (rnd == 5'(i)) s = SHIFT[i];
        end
        return s;
    endfunction

    function automatic logic [1:PC1_W] pc1(input logic [1:KEY_W] k);
        logic [1:PC1_W] r;
        for (int i = 1; i <= 56; i++) r[i] = k[PC1[i]];
        return r;
    endfunction

    function automatic logic [1:CD_W] rotl28(input logic [1:CD_W] x, input logic [1:0] n);
        return (x << n) | (x >> (5'd28 - 5'(n)));
    endfunction

    function automatic logic [1:CD_W] rotr28(input logic [1:CD_W] x, input logic [1:0] n);
        return (x >> n) | (x << (5'd28 - 5'(n)));
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression: 56-bit C||D to 48-bit round key, bit 1 = MSB.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:PC1_W]    cd_i,
    output logic [1:SUBKEY_W] subkey_o
);

    always_comb begin
        subkey_o = '0;
        for (int i = 1; i <= 48; i++) subkey_o[i] = cd_i[PC2[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator issuing K1..K16 (or K16..K1) one per handshake.
// Optional key parity checker enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit ALLOW_RESTART = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                decrypt,
    input  logic [1:KEY_W]      key_in,
    input  logic                abort,
    input  logic                subkey_ack,
    output logic [1:SUBKEY_W]   subkey_out,
    output logic                subkey_valid,
    output logic [3:0]          round_num,
    output logic                busy,
    output logic                done
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    output logic                parity_err
`endif
);

    logic [0:0]      state_q, state_d;
    logic [1:CD_W]   c_q, c_d;
    logic [1:CD_W]   d_q, d_d;
    logic [3:0]      round_q, round_d;
    logic            dec_q, dec_d;
    logic            done_q, done_d;
    logic [1:PC1_W]  key_cd;
    logic            load;
    logic [1:0]      enc_sh, dec_sh;

    assign key_cd = pc1(key_in);
    assign load   = start && ((state_q == ST_IDLE) || ALLOW_RESTART);
    assign enc_sh = shift_of(5'(round_q) + 5'd2);
    assign dec_sh = shift_of(5'd16 - 5'(round_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    // Abort beats load, load beats the ack that would finish the sequence.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (load) begin
            state_d = ST_ACTIVE;
            round_d = 4'd0;
            dec_d   = decrypt;
            // C0D0 already yields K16; encrypt needs C1D1.
            if (decrypt) begin
                c_d = key_cd[1:CD_W];
                d_d = key_cd[CD_W+1:PC1_W];
            end else begin
                c_d = rotl28(key_cd[1:CD_W], 2'd1);
                d_d = rotl28(key_cd[CD_W+1:PC1_W], 2'd1);
            end
        end else if ((state_q == ST_ACTIVE) && subkey_ack) begin
            if (round_q == 4'd15) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                round_d = round_q + 4'd1;
                if (dec_q) begin
                    c_d = rotr28(c_q, dec_sh);
                    d_d = rotr28(d_q, dec_sh);
                end else begin
                    c_d = rotl28(c_q, enc_sh);
                    d_d = rotl28(d_q, enc_sh);
                end
            end
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey_out)
    );

    assign subkey_valid = (state_q == ST_ACTIVE);
    assign busy         = (state_q == ST_ACTIVE);
    assign round_num    = round_q;
    assign done         = done_q;

`ifdef DES_KEY_PARITY_CHK_EN
    logic par_bad;
    logic par_q;

    // A DES key byte should carry odd parity.
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (~^key_in[8*i+1 +: 8]) par_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load && !abort) begin
            par_q <= par_bad;
        end
    end

    assign parity_err = par_q;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule with a reference DES key-schedule model.
module tb_des_key_schedule;

    localparam bit ALLOW_RESTART = 1'b0;
    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int TB_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        reset, start, decrypt, abort, subkey_ack;
    logic [63:0] key_in;
    logic [47:0] subkey_out;
    logic        subkey_valid;
    logic [3:0]  round_num;
    logic        busy, done;
`ifdef DES_KEY_PARITY_CHK_EN
    logic        parity_err;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    des_key_schedule #(.ALLOW_RESTART(ALLOW_RESTART)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .abort        (abort),
        .subkey_ack   (subkey_ack),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .round_num    (round_num),
        .busy         (busy),
        .done         (done)
`ifdef DES_KEY_PARITY_CHK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    // Kn straight from the textbook definition: cumulative rotation of C0D0, then PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int          s;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-TB_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        s = 0;
        for (int i = 0; i < n; i++) s += TB_SHIFT[i];
        for (int i = 0; i < s; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int j = 0; j < 48; j++) k[47-j] = cd[56-TB_PC2[j]];
        return k;
    endfunction

    function automatic bit even_byte(input logic [63:0] key);
        bit e;
        e = 1'b0;
        for (int i = 0; i < 8; i++) if (^key[8*i +: 8] == 1'b0) e = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: which key of the schedule is on offer, if any.
    bit          m_active, m_dec, m_done, m_zero, m_par;
    int          m_idx;
    logic [63:0] m_key;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_idx    <= 0;
            m_done   <= 1'b0;
            m_zero   <= 1'b1;
            m_par    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (abort) begin
                m_active <= 1'b0;
            end else if (start && (!m_active || ALLOW_RESTART)) begin
                m_key    <= key_in;
                m_dec    <= decrypt;
                m_idx    <= 0;
                m_active <= 1'b1;
                m_zero   <= 1'b0;
                m_par    <= even_byte(key_in);
            end else if (m_active && subkey_ack) begin
                if (m_idx == 15) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(subkey_valid), 64'(m_active));
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            if (m_active) begin
                chk("round_num", 64'(round_num), 64'(m_idx));
                chk("subkey", 64'(subkey_out), 64'(ref_subkey(m_key, m_dec ? 16 - m_idx : m_idx + 1)));
            end else if (m_zero) begin
                chk("reset_subkey", 64'(subkey_out), 64'd0);
                chk("reset_round", 64'(round_num), 64'd0);
            end
`ifdef DES_KEY_PARITY_CHK_EN
            chk("parity_err", 64'(parity_err), 64'(m_par));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(subkey_valid && round_num == r) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL wait_round: round_num=%0d required %0d", round_num, r);
        end
    endtask

    task automatic go(input logic [63:0] k, input logic dec);
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
        subkey_ack = 1'b0; key_in = '0;
        tick();
        tick();
        chk_en = 1'b1;
        reset = 1'b0;
        tick();

        chk("model_k1", 64'(ref_subkey(KEY_A, 1)), 64'h1B02EFFC7072);
        chk("model_k2", 64'(ref_subkey(KEY_A, 2)), 64'h79AED9DBC9E5);
        chk("model_k16", 64'(ref_subkey(KEY_A, 16)), 64'hCB3D8B0E17F5);

        // encrypt, ack held high
        subkey_ack = 1'b1;
        go(KEY_A, 1'b0);
        chk("enc_first", 64'(subkey_out), 64'h1B02EFFC7072);
        chk("enc_first_round", 64'(round_num), 64'd0);
        tick();
        chk("enc_second", 64'(subkey_out), 64'h79AED9DBC9E5);
        run_to_round(4'd15);
        chk("enc_last", 64'(subkey_out), 64'hCB3D8B0E17F5);
        tick();
        chk("enc_done", 64'(done), 64'd1);
        tick();
        chk("enc_done_once", 64'(done), 64'd0);

        // decrypt
        go(KEY_A, 1'b1);
        chk("dec_first", 64'(subkey_out), 64'hCB3D8B0E17F5);
        run_to_round(4'd15);
        chk("dec_last", 64'(subkey_out), 64'h1B02EFFC7072);
        tick();
        chk("dec_done", 64'(done), 64'd1);
        tick();

        // ack stall at round 4
        go(KEY_A, 1'b0);
        run_to_round(4'd4);
        subkey_ack = 1'b0;
        repeat (3) tick();
        chk("stall_round", 64'(round_num), 64'd4);
        chk("stall_key", 64'(subkey_out), 64'(ref_subkey(KEY_A, 5)));
        subkey_ack = 1'b1;
        run_to_round(4'd15);
        tick();
        chk("stall_done", 64'(done), 64'd1);
        tick();

        // abort at round 7, then a fresh start
        go(KEY_A, 1'b0);
        run_to_round(4'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (20) tick();
        go(KEY_A, 1'b0);
        chk("after_abort_k1", 64'(subkey_out), 64'h1B02EFFC7072);

        // reset mid-sequence
        run_to_round(4'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_subkey", 64'(subkey_out), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        tick();

        // start while active is ignored, including alongside the final ack
        go(KEY_A, 1'b0);
        run_to_round(4'd5);
        go(KEY_B, 1'b1);
        chk("restart_ignored", 64'(subkey_out), 64'(ref_subkey(KEY_A, 7)));
        run_to_round(4'd15);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("final_ack_done", 64'(done), 64'd1);
        chk("final_ack_idle", 64'(busy), 64'd0);
        tick();

`ifdef DES_KEY_PARITY_CHK_EN
        go(KEY_A, 1'b0);
        chk("parity_ok", 64'(parity_err), 64'd0);
        run_to_round(4'd15);
        tick();
        go(64'h133457799BBCDFF0, 1'b0);
        chk("parity_bad", 64'(parity_err), 64'd1);
        chk("parity_bad_valid", 64'(subkey_valid), 64'd1);
        run_to_round(4'd15);
        tick();
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
